rot_value: RTL and testbench



---
 rtl/rot_value_pkg.sv | 18 +
 rtl/rot_gap_timer.sv | 58 +++++
 rtl/rot_value.sv | 141 ++++++++++++++
 tb/tb_rot_value.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_value_pkg.sv
// Shared definitions for the rotary value block: mode encoding and the
// direction constants used by both the encoder decoder and rot_value.
package rot_value_pkg;

    typedef enum logic {
        MODE_SLOW = 1'b0,
        MODE_FAST = 1'b1
    } mode_t;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;

    // Number of distinct values in the inclusive range [lo, hi].
    function automatic int span(input int lo, input int hi);
        return hi - lo + 1;
    endfunction

endpackage

// File: rtl/rot_gap_timer.sv
// Measures the gap between accepted detent events and decides whether each
// event is a "quick" continuation of a same-direction burst.
module rot_gap_timer
    import rot_value_pkg::*;
#(
    parameter int FAST_WINDOW = 500000,
    parameter int FAST_COUNT  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic event_,
    input  logic right_,
    input  logic clear,
    output logic quick,
    output logic enter_fast,
    output logic timeout
);

    localparam int TW = $clog2(FAST_WINDOW + 1);
    localparam int CW = $clog2(FAST_COUNT + 1);

    localparam logic [TW-1:0] WINDOW = TW'(FAST_WINDOW);
    localparam logic [CW-1:0] COUNT  = CW'(FAST_COUNT);

    logic [TW-1:0] timer;
    logic [CW-1:0] quick_cnt;
    logic [CW-1:0] cnt_inc;
    logic          last_dir;

    assign quick      = (timer < WINDOW) && (right_ == last_dir);
    assign timeout    = (timer == WINDOW);
    assign cnt_inc    = (quick_cnt == COUNT) ? COUNT : quick_cnt + 1'b1;
    // Also true for quick events while already fast; the mode register just stays FAST.
    assign enter_fast = event_ && quick && (cnt_inc == COUNT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer     <= WINDOW;
            quick_cnt <= '0;
            last_dir  <= DIR_RIGHT;
        end else begin
            if (event_) begin
                timer    <= '0;
                last_dir <= right_;
            end else if (timer != WINDOW) begin
                timer <= timer + 1'b1;
            end

            if (clear || (event_ && !quick) || (!event_ && timeout)) begin
                quick_cnt <= '0;
            end else if (event_) begin
                quick_cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/rot_value.sv
// Bounded up/down value driven by rotary-encoder detents, with a fast step
// after a quick run of same-direction detents.
module rot_value
    import rot_value_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MIN         = 0,
    parameter int MAX         = 255,
    parameter int INIT        = 0,
    parameter int STEP_SLOW   = 1,
    parameter int STEP_FAST   = 8,
    parameter int FAST_WINDOW = 500000,
    parameter int FAST_COUNT  = 3,
    parameter int WRAP        = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             event_,
    input  logic             right_,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             changed,
    output logic             fast,
    output logic             at_min,
    output logic             at_max
);

    localparam int EW = WIDTH + 1;

    localparam logic [WIDTH:0]   MIN_E   = EW'(MIN);
    localparam logic [WIDTH:0]   MAX_E   = EW'(MAX);
    localparam logic [WIDTH:0]   RANGE_E = EW'(span(MIN, MAX));
    localparam logic [WIDTH:0]   SLOW_E  = EW'(STEP_SLOW);
    localparam logic [WIDTH:0]   FAST_E  = EW'(STEP_FAST);
    localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] INIT_V  = WIDTH'(INIT);
    localparam bit               WRAP_EN = (WRAP != 0);

    mode_t            mode;
    logic             accept;
    logic             quick;
    logic             enter_fast;
    logic             timeout;
    logic [WIDTH:0]   value_e;
    logic [WIDTH:0]   step_e;
    logic [WIDTH:0]   sum_e;
    logic [WIDTH:0]   load_lo;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step_value;
    logic [WIDTH-1:0] value_nxt;

    // A load in the same cycle swallows the event entirely.
    assign accept = event_ && !load;

    rot_gap_timer #(
        .FAST_WINDOW (FAST_WINDOW),
        .FAST_COUNT  (FAST_COUNT)
    ) u_gap_timer (
        .clk        (clk),
        .rst        (rst),
        .event_     (accept),
        .right_     (right_),
        .clear      (load),
        .quick      (quick),
        .enter_fast (enter_fast),
        .timeout    (timeout)
    );

    // The lower clamp only exists when MIN is above zero.
    if (MIN > 0) begin : g_lo_clamp
        assign load_lo = ({1'b0, load_value} < MIN_E) ? MIN_E : {1'b0, load_value};
    end else begin : g_lo_pass
        assign load_lo = {1'b0, load_value};
    end

    assign load_clamped = (load_lo > MAX_E) ? MAX_V : WIDTH'(load_lo);

    assign value_e = {1'b0, value};
    assign step_e  = (mode == MODE_FAST && quick) ? FAST_E : SLOW_E;
    assign sum_e   = value_e + step_e;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        step_value = value;
        case (right_)
            DIR_RIGHT: begin
                if (sum_e > MAX_E) begin
                    step_value = WRAP_EN ? WIDTH'(sum_e - RANGE_E) : MAX_V;
                end else begin
                    step_value = WIDTH'(sum_e);
                end
            end
            DIR_LEFT: begin
                if (value_e < MIN_E + step_e) begin
                    step_value = WRAP_EN ? WIDTH'(value_e + RANGE_E - step_e) : MIN_V;
                end else begin
                    step_value = WIDTH'(value_e - step_e);
                end
            end
        endcase
    end

    always_comb begin
        value_nxt = value;
        if (load) begin
            value_nxt = load_clamped;
        end else if (accept) begin
            value_nxt = step_value;
        end
    end

    // Value, strobe and mode FSM share one register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            value   <= INIT_V;
            changed <= 1'b0;
            mode    <= MODE_SLOW;
        end else begin
            value   <= value_nxt;
            changed <= (value_nxt != value);
            if (load) begin
                mode <= MODE_SLOW;
            end else if (accept) begin
                if (!quick) begin
                    mode <= MODE_SLOW;
                end else if (enter_fast) begin
                    mode <= MODE_FAST;
                end
            end else if (timeout) begin
                mode <= MODE_SLOW;
            end
        end
    end

    assign fast   = (mode == MODE_FAST);
    assign at_min = (value == MIN_V);
    assign at_max = (value == MAX_V);

endmodule

// File: tb/tb_rot_value.sv
// Bench for rot_value: four parameter sets share one stimulus stream and are
// compared against a timestamp-based reference model.
module tb_rot_value;

    localparam int N = 4;
    localparam int C_MIN  [N] = '{0, 0, 5, 5};
    localparam int C_MAX  [N] = '{255, 255, 200, 200};
    localparam int C_INIT [N] = '{0, 0, 100, 7};
    localparam int C_SLOW [N] = '{1, 1, 1, 3};
    localparam int C_FAST [N] = '{8, 8, 8, 20};
    localparam int C_FW   [N] = '{16, 16, 16, 10};
    localparam int C_FC   [N] = '{3, 3, 3, 2};
    localparam int C_WRAP [N] = '{0, 1, 0, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       event_ = 1'b0;
    logic       right_ = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'd0;

    logic [7:0] value   [N];
    logic       changed [N];
    logic       fast    [N];
    logic       at_min  [N];
    logic       at_max  [N];

    int  m_val  [N];
    int  m_cnt  [N];
    int  m_last [N];
    bit  m_fast [N];
    bit  m_chg  [N];
    bit  m_dir  [N];
    int  cyc = 0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rot_value #(.WIDTH(8), .MIN(0), .MAX(255), .INIT(0), .STEP_SLOW(1), .STEP_FAST(8),
                .FAST_WINDOW(16), .FAST_COUNT(3), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .event_(event_), .right_(right_), .load(load),
        .load_value(load_value), .value(value[0]), .changed(changed[0]), .fast(fast[0]),
        .at_min(at_min[0]), .at_max(at_max[0]));

    rot_value #(.WIDTH(8), .MIN(0), .MAX(255), .INIT(0), .STEP_SLOW(1), .STEP_FAST(8),
                .FAST_WINDOW(16), .FAST_COUNT(3), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .event_(event_), .right_(right_), .load(load),
        .load_value(load_value), .value(value[1]), .changed(changed[1]), .fast(fast[1]),
        .at_min(at_min[1]), .at_max(at_max[1]));

    rot_value #(.WIDTH(8), .MIN(5), .MAX(200), .INIT(100), .STEP_SLOW(1), .STEP_FAST(8),
                .FAST_WINDOW(16), .FAST_COUNT(3), .WRAP(0)) u_clip (
        .clk(clk), .rst(rst), .event_(event_), .right_(right_), .load(load),
        .load_value(load_value), .value(value[2]), .changed(changed[2]), .fast(fast[2]),
        .at_min(at_min[2]), .at_max(at_max[2]));

    rot_value #(.WIDTH(8), .MIN(5), .MAX(200), .INIT(7), .STEP_SLOW(3), .STEP_FAST(20),
                .FAST_WINDOW(10), .FAST_COUNT(2), .WRAP(1)) u_wrap_off (
        .clk(clk), .rst(rst), .event_(event_), .right_(right_), .load(load),
        .load_value(load_value), .value(value[3]), .changed(changed[3]), .fast(fast[3]),
        .at_min(at_min[3]), .at_max(at_max[3]));

    // Reference model: quickness from event timestamps, value from plain integer arithmetic.
    task automatic model_step(input bit s_rst, input bit s_ev, input bit s_right,
                              input bit s_load, input int s_lv);
        int  nv;
        int  step;
        int  gap;
        int  range;
        bit  quick;
        cyc++;
        for (int i = 0; i < N; i++) begin
            range = C_MAX[i] - C_MIN[i] + 1;
            if (s_rst) begin
                m_val[i]  = C_INIT[i];
                m_fast[i] = 1'b0;
                m_cnt[i]  = 0;
                m_dir[i]  = 1'b1;
                m_last[i] = cyc - 1000000;
                m_chg[i]  = 1'b0;
            end else begin
                nv = m_val[i];
                if (s_load) begin
                    nv = (s_lv < C_MIN[i]) ? C_MIN[i] : (s_lv > C_MAX[i]) ? C_MAX[i] : s_lv;
                    m_fast[i] = 1'b0;
                    m_cnt[i]  = 0;
                end else if (s_ev) begin
                    gap   = cyc - m_last[i] - 1;
                    quick = (gap < C_FW[i]) && (s_right == m_dir[i]);
                    step  = C_SLOW[i];
                    if (!quick) begin
                        m_cnt[i]  = 0;
                        m_fast[i] = 1'b0;
                    end else if (m_fast[i]) begin
                        step = C_FAST[i];
                    end else begin
                        m_cnt[i] = (m_cnt[i] + 1 > C_FC[i]) ? C_FC[i] : m_cnt[i] + 1;
                        if (m_cnt[i] == C_FC[i]) m_fast[i] = 1'b1;
                    end
                    nv = s_right ? nv + step : nv - step;
                    if (nv > C_MAX[i]) nv = (C_WRAP[i] != 0) ? nv - range : C_MAX[i];
                    if (nv < C_MIN[i]) nv = (C_WRAP[i] != 0) ? nv + range : C_MIN[i];
                    m_last[i] = cyc;
                    m_dir[i]  = s_right;
                end else if (cyc - m_last[i] - 1 >= C_FW[i]) begin
                    m_fast[i] = 1'b0;
                    m_cnt[i]  = 0;
                end
                m_chg[i] = (nv != m_val[i]);
                m_val[i] = nv;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, sample 1 time unit later.
    task automatic tick(input bit t_rst, input bit t_ev, input bit t_right,
                        input bit t_load, input int t_lv);
        rst        = t_rst;
        event_     = t_ev;
        right_     = t_right;
        load       = t_load;
        load_value = 8'(t_lv);
        @(posedge clk);
        model_step(t_rst, t_ev, t_right, t_load, t_lv);
        #1;
        rst    = 1'b0;
        event_ = 1'b0;
        load   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'($urandom_range(1, 0)), 1'b0, 0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic right_event();
        tick(1'b0, 1'b1, 1'b1, 1'b0, 0);
    endtask

    task automatic left_event();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (value[i] !== 8'(C_INIT[i])) begin
                n_fail++; $display("FAIL reset value[%0d]: got %0d expected %0d", i, value[i], C_INIT[i]);
            end
            n_tests++;
            if (changed[i] !== 1'b0 || fast[i] !== 1'b0) begin
                n_fail++; $display("FAIL reset flags[%0d]: changed=%b fast=%b expected 0 0", i, changed[i], fast[i]);
            end
            n_tests++;
            if (at_min[i] !== (C_INIT[i] == C_MIN[i]) || at_max[i] !== (C_INIT[i] == C_MAX[i])) begin
                n_fail++; $display("FAIL reset bounds[%0d]: at_min=%b at_max=%b", i, at_min[i], at_max[i]);
            end
        end
    endtask

    task automatic test_first_event();
        do_reset();
        idle(2);
        right_event();
        n_tests++;
        if (value[0] !== 8'd1 || changed[0] !== 1'b1 || fast[0] !== 1'b0) begin
            n_fail++; $display("FAIL first_event: value=%0d changed=%b fast=%b expected 1 1 0", value[0], changed[0], fast[0]);
        end
        idle(1);
        n_tests++;
        if (value[0] !== 8'd1 || changed[0] !== 1'b0) begin
            n_fail++; $display("FAIL first_event_pulse: value=%0d changed=%b expected 1 0", value[0], changed[0]);
        end
    endtask

    task automatic test_bounds();
        do_reset();
        left_event();
        n_tests++;
        if (value[0] !== 8'd0 || changed[0] !== 1'b0 || at_min[0] !== 1'b1) begin
            n_fail++; $display("FAIL sat_at_min: value=%0d changed=%b at_min=%b expected 0 0 1", value[0], changed[0], at_min[0]);
        end
        n_tests++;
        if (value[1] !== 8'd255 || changed[1] !== 1'b1 || at_max[1] !== 1'b1) begin
            n_fail++; $display("FAIL wrap_under: value=%0d changed=%b at_max=%b expected 255 1 1", value[1], changed[1], at_max[1]);
        end
    endtask

    task automatic test_accel();
        int exp_v [5] = '{1, 2, 3, 4, 12};
        do_reset();
        idle(3);
        for (int k = 0; k < 5; k++) begin
            right_event();
            n_tests++;
            if (value[0] !== 8'(exp_v[k]) || fast[0] !== (k >= 3)) begin
                n_fail++; $display("FAIL accel[%0d]: value=%0d fast=%b expected %0d %0d", k, value[0], fast[0], exp_v[k], k >= 3);
            end
            if (k < 4) idle(3);
        end
        idle(16);
        n_tests++;
        if (fast[0] !== 1'b1) begin
            n_fail++; $display("FAIL accel_hold: fast=%b expected 1", fast[0]);
        end
        idle(1);
        n_tests++;
        if (fast[0] !== 1'b0) begin
            n_fail++; $display("FAIL accel_timeout: fast=%b expected 0", fast[0]);
        end
        idle(2);
        right_event();
        n_tests++;
        if (value[0] !== 8'd13 || fast[0] !== 1'b0) begin
            n_fail++; $display("FAIL accel_after_timeout: value=%0d fast=%b expected 13 0", value[0], fast[0]);
        end
    endtask

    task automatic test_reversal();
        int exp_v [6] = '{11, 10, 9, 8, 0, 0};
        bit exp_f [6] = '{0, 0, 0, 1, 1, 1};
        do_reset();
        idle(3);
        for (int k = 0; k < 5; k++) begin
            right_event();
            idle(3);
        end
        for (int k = 0; k < 6; k++) begin
            left_event();
            n_tests++;
            if (value[0] !== 8'(exp_v[k]) || fast[0] !== exp_f[k] || changed[0] !== (k != 5)) begin
                n_fail++; $display("FAIL reversal[%0d]: value=%0d fast=%b changed=%b expected %0d %0d %0d",
                                   k, value[0], fast[0], changed[0], exp_v[k], exp_f[k], k != 5);
            end
            idle(3);
        end
    endtask

    task automatic test_load_priority();
        do_reset();
        idle(2);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 250);
        n_tests++;
        if (value[2] !== 8'd200 || at_max[2] !== 1'b1 || changed[2] !== 1'b1) begin
            n_fail++; $display("FAIL load_clamp_hi: value=%0d at_max=%b changed=%b expected 200 1 1", value[2], at_max[2], changed[2]);
        end
        n_tests++;
        if (value[0] !== 8'd250) begin
            n_fail++; $display("FAIL load_full_range: value=%0d expected 250", value[0]);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1, 2);
        n_tests++;
        if (value[2] !== 8'd5 || at_min[2] !== 1'b1 || changed[2] !== 1'b1) begin
            n_fail++; $display("FAIL load_clamp_lo: value=%0d at_min=%b changed=%b expected 5 1 1", value[2], at_min[2], changed[2]);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1, 0);
        n_tests++;
        if (value[2] !== 8'd5 || changed[2] !== 1'b0) begin
            n_fail++; $display("FAIL load_same: value=%0d changed=%b expected 5 0", value[2], changed[2]);
        end
        // Enter fast, then load with a left event: the event must leave direction history alone.
        do_reset();
        idle(3);
        for (int k = 0; k < 4; k++) begin
            right_event();
            idle(3);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b1, 100);
        n_tests++;
        if (value[0] !== 8'd100 || fast[0] !== 1'b0) begin
            n_fail++; $display("FAIL load_forces_slow: value=%0d fast=%b expected 100 0", value[0], fast[0]);
        end
        for (int k = 0; k < 3; k++) begin
            idle(3);
            right_event();
        end
        n_tests++;
        if (value[0] !== 8'd103 || fast[0] !== 1'b1) begin
            n_fail++; $display("FAIL load_drops_event: value=%0d fast=%b expected 103 1", value[0], fast[0]);
        end
    endtask

    task automatic test_reset_override();
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 12);
        idle(3);
        for (int k = 0; k < 7; k++) begin
            right_event();
            if (k < 6) idle(3);
        end
        n_tests++;
        if (value[0] !== 8'd40 || fast[0] !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: value=%0d fast=%b expected 40 1", value[0], fast[0]);
        end
        idle(3);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 0);
        n_tests++;
        if (value[0] !== 8'd0 || fast[0] !== 1'b0 || changed[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_override: value=%0d fast=%b changed=%b expected 0 0 0", value[0], fast[0], changed[0]);
        end
        idle(3);
        right_event();
        n_tests++;
        if (value[0] !== 8'd1 || changed[0] !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_event: value=%0d changed=%b expected 1 1", value[0], changed[0]);
        end
    endtask

    task automatic test_random();
        bit burst = 1'b0;
        bit dir   = 1'b1;
        bit r_rst, r_ev, r_right, r_load;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) burst = 1'($urandom_range(1, 0));
            if ($urandom_range(19, 0) == 0) dir = ~dir;
            r_rst   = ($urandom_range(499, 0) == 0);
            r_load  = ($urandom_range(39, 0) == 0);
            r_ev    = burst ? ($urandom_range(2, 0) == 0) : ($urandom_range(24, 0) == 0);
            r_right = r_ev ? dir : 1'($urandom_range(1, 0));
            tick(r_rst, r_ev, r_right, r_load, int'($urandom_range(255, 0)));
            for (int i = 0; i < N; i++) begin
                n_tests++;
                if (value[i] !== 8'(m_val[i])) begin
                    n_fail++; $display("FAIL rand value[%0d] cyc %0d: got %0d expected %0d", i, cyc, value[i], m_val[i]);
                end
                n_tests++;
                if (changed[i] !== m_chg[i]) begin
                    n_fail++; $display("FAIL rand changed[%0d] cyc %0d: got %b expected %b", i, cyc, changed[i], m_chg[i]);
                end
                n_tests++;
                if (fast[i] !== m_fast[i]) begin
                    n_fail++; $display("FAIL rand fast[%0d] cyc %0d: got %b expected %b", i, cyc, fast[i], m_fast[i]);
                end
                n_tests++;
                if (at_min[i] !== (m_val[i] == C_MIN[i]) || at_max[i] !== (m_val[i] == C_MAX[i])) begin
                    n_fail++; $display("FAIL rand bounds[%0d] cyc %0d: at_min=%b at_max=%b value %0d", i, cyc, at_min[i], at_max[i], m_val[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_event();
        test_bounds();
        test_accel();
        test_reversal();
        test_load_priority();
        test_reset_override();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
